fetch_sequencer: RTL and testbench

- Multi-cycle FSM sequencer; sits directly upstream of the instruction decoder/control unit.
- Owns the program counter and fetches 16-bit instructions from instruction memory over a req/valid handshake.
- Holds each instruction stable in an instruction register (IR) for the decoder.
- Emits one-cycle DECODE/EXECUTE/WRITEBACK phase strobes that the datapath uses to qualify ALU and register-file writes.

---
 rtl/fetch_sequencer.sv | 119 +++++++++++
 tb/tb_fetch_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer.
// Owns the program counter, fetches 16-bit instructions over a req/valid
// handshake, holds them in the IR and emits one-cycle phase strobes.
module fetch_sequencer #(
    parameter int unsigned            PC_WIDTH      = 8,
    parameter logic [PC_WIDTH-1:0]    START_ADDR    = '0,
    parameter int unsigned            FETCH_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_rdata,
    input  logic                imem_valid,
    output logic [15:0]         instruction,
    output logic                decode_stb,
    output logic                exec_stb,
    output logic                wb_stb,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                halted,
    output logic                fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [2:0] OP_HALT  = 3'b111;
    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] tmo_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection; a valid response in the last allowed fetch cycle wins over the timeout.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid)              state_nx = S_DECODE;
                else if (tmo_cnt == TMO_LAST) state_nx = S_ERROR;
            end
            S_DECODE: begin
                if (instruction[15:13] == OP_HALT) state_nx = S_HALT;
                else                               state_nx = S_EXECUTE;
            end
            S_EXECUTE:   state_nx = S_WRITEBACK;
            S_WRITEBACK: state_nx = S_FETCH;
            S_HALT, S_ERROR: begin
                if (start) state_nx = S_FETCH;
            end
            default:     state_nx = S_IDLE;
        endcase
    end

    // PC, instruction register and fetch timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= START_ADDR;
            instruction <= '0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        instruction <= imem_rdata;
                        tmo_cnt     <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt     <= '0;
                    end else begin
                        tmo_cnt     <= tmo_cnt + 8'd1;
                    end
                end
                S_WRITEBACK: begin
                    pc <= pc + PC_WIDTH'(1);
                end
                S_HALT, S_ERROR: begin
                    if (start) pc <= START_ADDR;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state register only.
    always_comb begin
        imem_req   = (state == S_FETCH);
        decode_stb = (state == S_DECODE);
        exec_stb   = (state == S_EXECUTE);
        wb_stb     = (state == S_WRITEBACK);
        busy       = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_EXECUTE) || (state == S_WRITEBACK);
        halted     = (state == S_HALT);
        fetch_err  = (state == S_ERROR);
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by random
// start/memory-wait/spurious-valid traffic, checked every cycle against an
// instruction-level reference model (running flag + phase within instruction).
module tb_fetch_sequencer;

    localparam int unsigned   PW      = 8;
    localparam logic [PW-1:0] START   = 8'hFE;
    localparam int            TIMEOUT = 15;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic          imem_valid;
    logic [15:0]   instruction;
    logic          decode_stb;
    logic          exec_stb;
    logic          wb_stb;
    logic [PW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          fetch_err;

    fetch_sequencer #(
        .PC_WIDTH      (PW),
        .START_ADDR    (START),
        .FETCH_TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instruction (instruction),
        .decode_stb  (decode_stb),
        .exec_stb    (exec_stb),
        .wb_stb      (wb_stb),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0=fetch 1=decode 2=execute 3=writeback while running.
    bit            m_run, m_halt, m_err;
    int            m_phase, m_wait;
    logic [PW-1:0] m_pc;
    logic [15:0]   m_ir;

    // Memory model
    logic [15:0] mem [256];
    int          wait_left;
    int          wait_first;
    int          wait_cfg;

    function automatic int pick_wait(input int cfg);
        if (cfg >= 0) return cfg;
        if ($urandom % 16 == 0) return 20;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_err = 0;
        m_phase = 0; m_wait = 0;
        m_pc = START; m_ir = 16'h0000;
    endtask

    task automatic model_edge(input logic st, input logic vld, input logic [15:0] d);
        if (!m_run) begin
            if (st) begin
                m_pc = START; m_halt = 0; m_err = 0;
                m_run = 1; m_phase = 0; m_wait = 0;
                wait_left = pick_wait(wait_first);
            end
        end else begin
            case (m_phase)
                0: begin
                    if (vld) begin
                        m_ir = d; m_wait = 0; m_phase = 1;
                    end else if (m_wait == TIMEOUT - 1) begin
                        m_wait = 0; m_run = 0; m_err = 1;
                    end else begin
                        m_wait++;
                    end
                end
                1: begin
                    if (m_ir[15:13] == 3'b111) begin
                        m_run = 0; m_halt = 1;
                    end else begin
                        m_phase = 2;
                    end
                end
                2: m_phase = 3;
                default: begin
                    m_pc = m_pc + 1'b1;
                    m_phase = 0;
                    wait_left = pick_wait(wait_cfg);
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("imem_req",    16'(imem_req),   16'(m_run && m_phase == 0));
        chk("imem_addr",   16'(imem_addr),  16'(m_pc));
        chk("pc",          16'(pc),         16'(m_pc));
        chk("instruction", instruction,     m_ir);
        chk("decode_stb",  16'(decode_stb), 16'(m_run && m_phase == 1));
        chk("exec_stb",    16'(exec_stb),   16'(m_run && m_phase == 2));
        chk("wb_stb",      16'(wb_stb),     16'(m_run && m_phase == 3));
        chk("busy",        16'(busy),       16'(m_run));
        chk("halted",      16'(halted),     16'(m_halt));
        chk("fetch_err",   16'(fetch_err),  16'(m_err));
    endtask

    task automatic step(input logic st, input logic vld, input logic [15:0] d);
        start = st; imem_valid = vld; imem_rdata = d;
        @(posedge clk);
        model_edge(st, vld, d);
        #1;
        check_all();
    endtask

    // Responds to fetches from the model's view of the bus; spurious valids elsewhere.
    task automatic mem_step(input logic st, input bit spur);
        logic        vld;
        logic [15:0] d;
        d = 16'($urandom);
        if (m_run && m_phase == 0) begin
            if (wait_left > 0) begin
                vld = 1'b0;
                wait_left--;
            end else begin
                vld = 1'b1;
                d   = mem[m_pc];
            end
        end else begin
            vld = spur && ($urandom % 3 == 0);
        end
        step(st, vld, d);
    endtask

    task automatic run(input int n, input bit st_rand, input bit spur);
        for (int i = 0; i < n; i++) begin
            mem_step(st_rand && ($urandom % 6 == 0), spur);
        end
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        wait_left = 0; wait_first = 0; wait_cfg = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        model_reset();
        #12;
        check_all();
        chk("rst_pc", 16'(pc), 16'h00FE);
        rst_n = 1'b1;

        // Zero-wait program: two instructions then HALT at the third address.
        mem[8'hFE] = 16'h2C40; mem[8'hFF] = 16'h0A00; mem[8'h00] = 16'hE000;
        wait_first = 0; wait_cfg = 0;
        mem_step(1'b1, 1'b0);
        run(12, 1'b0, 1'b0);
        chk("halt_flag", 16'(halted), 16'h0001);
        chk("halt_pc",   16'(pc),     16'h0000);
        chk("halt_req",  16'(imem_req), 16'h0000);

        // Three wait cycles on the first fetch.
        mem[8'hFE] = 16'h1234; mem[8'hFF] = 16'hE000;
        wait_first = 3;
        mem_step(1'b1, 1'b0);
        run(12, 1'b0, 1'b0);

        // Memory never answers: error after exactly TIMEOUT fetch cycles.
        wait_first = 100;
        mem_step(1'b1, 1'b0);
        run(TIMEOUT, 1'b0, 1'b0);
        chk("tmo_err", 16'(fetch_err), 16'h0001);
        chk("tmo_req", 16'(imem_req),  16'h0000);

        // Valid in the final allowed cycle wins.
        mem[8'hFE] = 16'h1000; mem[8'hFF] = 16'hE000;
        wait_first = TIMEOUT - 1;
        mem_step(1'b1, 1'b0);
        run(TIMEOUT, 1'b0, 1'b0);
        chk("late_dec", 16'(decode_stb), 16'h0001);
        chk("late_err", 16'(fetch_err),  16'h0000);
        run(8, 1'b0, 1'b0);

        // PC wrap: FE, FF, 00, 01 then HALT at 02; includes a NOP.
        mem[8'hFE] = 16'h0001; mem[8'hFF] = 16'h4002; mem[8'h00] = 16'h8003;
        mem[8'h01] = 16'hC004; mem[8'h02] = 16'hE000;
        wait_first = 0;
        mem_step(1'b1, 1'b0);
        run(20, 1'b0, 1'b0);
        chk("wrap_pc",   16'(pc),     16'h0002);
        chk("wrap_halt", 16'(halted), 16'h0001);

        // Start pulses and spurious valids while busy.
        mem[8'hFE] = 16'h2C40; mem[8'hFF] = 16'h0A00; mem[8'h00] = 16'hE000;
        wait_cfg = 1;
        mem_step(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) mem_step(1'b1, 1'b1);
        run(4, 1'b0, 1'b0);
        wait_cfg = 0;

        // Asynchronous reset during EXECUTE.
        mem[8'hFE] = 16'h2C40; mem[8'hFF] = 16'hE000;
        mem_step(1'b1, 1'b0);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            mem_step(1'b0, 1'b0);
            if (m_run && m_phase == 2) hit = 1;
        end
        chk("reach_exec", 16'(exec_stb), 16'(hit));
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3 rst_n = 1'b1;
        run(3, 1'b0, 1'b0);

        // Random traffic.
        wait_first = -1; wait_cfg = -1;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        run(800, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
